// File: rtl/wb_asmem_ctrl_if.sv
// wb_asmem_ctrl_if
//   Main WISHBONE classic bus between the system interconnect and the
//   asynchronous memory controller.
//   Signals (slave view):
//     wb_adr_i  [31:0]  byte address
//     wb_dat_i  [31:0]  write data
//     wb_sel_i  [3:0]   byte selects
//     wb_cyc_i, wb_stb_i, wb_we_i  classic cycle controls
//     wb_dat_o  [31:0]  read data, valid while wb_ack_o=1
//     wb_ack_o          normal termination
//     wb_err_o          error termination
interface wb_asmem_ctrl_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/wb_asmem_ctrl.sv
// wb_asmem_ctrl
//   WISHBONE classic slave driving asynchronous SRAM/ROM/IO pins directly.
//   NREG chip-select regions, each with a runtime-programmable base, mask,
//   wait states, write-protect and bus-ready enable, set via a small config
//   WISHBONE port. Adds per-region timing, bus-ready timeout and optional
//   byte-lane reversal for big-endian memories.
//   Ports:
//     clk, rst_n            clock / synchronous active-low reset
//     wb                    main WISHBONE slave (wb_asmem_ctrl_if.slave)
//     cfg_adr_i/dat_i/cyc_i/stb_i/we_i, cfg_dat_o, cfg_ack_o
//                           config register port (register per region)
//     mem_addr, mem_dout, mem_din, mem_drive
//                           memory address / data pins, pad drive enable
//     mem_csn[NREG], mem_oen, mem_wen[3:0]
//                           active-low chip selects and strobes
//     mem_brdyn             external bus ready, active-low
//   Config register layout: [31:20] base, [19:8] mask, [7:4] ws,
//     [3] wprot, [2] brdy_en, [1] reserved (0), [0] en.
module wb_asmem_ctrl #(
   parameter int          NREG    = 4,
   parameter logic [3:0]  DEF_WS  = 4'hF,
   parameter logic [11:0] R0_ADDR = 12'h000,
   parameter logic [11:0] R0_MASK = 12'hE00,
   parameter logic [7:0]  TOUT    = 8'd255,
   parameter int          BSWAP   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   wb_asmem_ctrl_if.slave   wb,
   input  logic [2:0]       cfg_adr_i,
   input  logic [31:0]      cfg_dat_i,
   input  logic             cfg_cyc_i,
   input  logic             cfg_stb_i,
   input  logic             cfg_we_i,
   output logic [31:0]      cfg_dat_o,
   output logic             cfg_ack_o,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_dout,
   input  logic [31:0]      mem_din,
   output logic             mem_drive,
   output logic [NREG-1:0]  mem_csn,
   output logic             mem_oen,
   output logic [3:0]       mem_wen,
   input  logic             mem_brdyn
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_ACCESS = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
   localparam logic [2:0] S_ERR    = 3'd4;

   localparam logic [31:0] R0_INIT = {R0_ADDR, R0_MASK, DEF_WS, 4'b0001};

   function automatic logic [31:0] lane_swap(input logic [31:0] d);
      if (BSWAP != 0)
         return {d[7:0], d[15:8], d[23:16], d[31:24]};
      else
         return d;
   endfunction

   function automatic logic [3:0] sel_swap(input logic [3:0] s);
      if (BSWAP != 0)
         return {s[0], s[1], s[2], s[3]};
      else
         return s;
   endfunction

   // ---------------------------------------------------------------
   // Config registers
   // ---------------------------------------------------------------
   logic [31:0] region_reg [NREG];
   logic        cfg_ack_reg;
   logic        cfg_wr;
   logic [31:0] cfg_rdata;

   // The write lands on the edge that ends the ack cycle.
   assign cfg_wr = cfg_ack_reg & cfg_cyc_i & cfg_stb_i & cfg_we_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_ack_reg <= 1'b0;
      end else begin
         // Held strobe is acked every other cycle.
         cfg_ack_reg <= cfg_cyc_i & cfg_stb_i & ~cfg_ack_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            region_reg[i] <= (i == 0) ? R0_INIT : 32'h0;
      end else if (cfg_wr) begin
         // Indices with no region simply match nothing here.
         for (int i = 0; i < NREG; i++)
            if (cfg_adr_i == 3'(i))
               region_reg[i] <= cfg_dat_i & 32'hFFFF_FFFD;
      end
   end

   always_comb begin
      cfg_rdata = 32'h0;
      for (int i = 0; i < NREG; i++)
         if (cfg_adr_i == 3'(i))
            cfg_rdata = region_reg[i];
   end

   assign cfg_dat_o = cfg_rdata;
   assign cfg_ack_o = cfg_ack_reg;

   // ---------------------------------------------------------------
   // Region decode (lowest index wins)
   // ---------------------------------------------------------------
   logic [NREG-1:0] hit;
   logic            hit_any;
   logic [2:0]      win_idx;
   logic [3:0]      win_ws;
   logic            win_wprot;
   logic            win_brdy;

   for (genvar gi = 0; gi < NREG; gi++) begin : g_hit
      assign hit[gi] = region_reg[gi][0] &
                       ((wb.wb_adr_i[31:20] & region_reg[gi][19:8]) == region_reg[gi][31:20]);
   end

   assign hit_any = |hit;

   always_comb begin
      win_idx   = 3'd0;
      win_ws    = 4'd0;
      win_wprot = 1'b0;
      win_brdy  = 1'b0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (hit[i]) begin
            win_idx   = 3'(i);
            win_ws    = region_reg[i][7:4];
            win_wprot = region_reg[i][3];
            win_brdy  = region_reg[i][2];
         end
      end
   end

   // ---------------------------------------------------------------
   // Main FSM
   // ---------------------------------------------------------------
   logic [2:0]  state_reg;
   logic [2:0]  reg_idx_reg;
   logic        we_reg;
   logic        brdy_en_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  lanes_reg;
   logic [3:0]  ws_cnt_reg;
   logic [7:0]  tout_cnt_reg;
   logic [31:0] rdata_reg;
   logic        abort_reg;
   logic        term_prev_reg;
   logic        wb_ack;
   logic        wb_err;
   logic        in_cycle;

   assign in_cycle = (state_reg == S_SETUP) | (state_reg == S_ACCESS) | (state_reg == S_HOLD);

   // Terminations are masked once the master has abandoned the cycle.
   assign wb_ack = (state_reg == S_HOLD) & ~abort_reg & wb.wb_cyc_i;
   assign wb_err = (state_reg == S_ERR)  & ~abort_reg & wb.wb_cyc_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         reg_idx_reg   <= 3'd0;
         we_reg        <= 1'b0;
         brdy_en_reg   <= 1'b0;
         addr_reg      <= 32'h0;
         wdata_reg     <= 32'h0;
         lanes_reg     <= 4'h0;
         ws_cnt_reg    <= 4'h0;
         tout_cnt_reg  <= 8'h0;
         rdata_reg     <= 32'h0;
         abort_reg     <= 1'b0;
         term_prev_reg <= 1'b0;
      end else begin
         term_prev_reg <= wb_ack | wb_err;
         if (in_cycle && !wb.wb_cyc_i)
            abort_reg <= 1'b1;

         case (state_reg)
            S_IDLE: begin
               // The cycle right after a termination still shows the old
               // strobe; it must not start a second access.
               if (wb.wb_cyc_i && wb.wb_stb_i && !term_prev_reg) begin
                  abort_reg <= 1'b0;
                  if (!hit_any || (wb.wb_we_i && win_wprot)) begin
                     state_reg <= S_ERR;
                  end else begin
                     reg_idx_reg  <= win_idx;
                     we_reg       <= wb.wb_we_i;
                     brdy_en_reg  <= win_brdy;
                     addr_reg     <= wb.wb_adr_i;
                     wdata_reg    <= wb.wb_dat_i;
                     lanes_reg    <= sel_swap(wb.wb_sel_i);
                     ws_cnt_reg   <= win_ws;
                     tout_cnt_reg <= 8'h0;
                     state_reg    <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               state_reg <= S_ACCESS;
            end
            S_ACCESS: begin
               if (ws_cnt_reg != 4'h0) begin
                  ws_cnt_reg <= ws_cnt_reg - 4'h1;
               end else if (!brdy_en_reg || !mem_brdyn) begin
                  if (!we_reg)
                     rdata_reg <= lane_swap(mem_din);
                  state_reg <= S_HOLD;
               end else if (({1'b0, tout_cnt_reg} + 9'd1) >= {1'b0, TOUT}) begin
                  state_reg <= S_ERR;
               end else begin
                  tout_cnt_reg <= tout_cnt_reg + 8'h1;
               end
            end
            S_HOLD: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   always_comb begin
      mem_csn = '1;
      if (in_cycle)
         for (int i = 0; i < NREG; i++)
            if (reg_idx_reg == 3'(i))
               mem_csn[i] = 1'b0;
   end

   assign mem_addr  = addr_reg;
   assign mem_dout  = lane_swap(wdata_reg);
   assign mem_drive = in_cycle & we_reg;
   assign mem_oen   = ~((state_reg == S_ACCESS) & ~we_reg);
   assign mem_wen   = ((state_reg == S_ACCESS) && we_reg) ? ~lanes_reg : 4'hF;

   assign wb.wb_dat_o = rdata_reg;
   assign wb.wb_ack_o = wb_ack;
   assign wb.wb_err_o = wb_err;

endmodule

// File: doc/wb_asmem_ctrl.md
Name: wb_asmem_ctrl

Overview:
Parametrised WISHBONE slave that drives async SRAM/ROM/IO directly, with no AHB bridge. It supports NREG chip-select regions. Each region has runtime-programmable base, mask, wait states, write-protect and bus-ready enable, set through a small config WISHBONE port. It sits between the system WISHBONE interconnect and the external memory pins, and adds per-region timing, bus-ready timeout and configurable byte-lane swap.

Parameters:
NREG, 4, number of regions / chip selects (1..8)
DEF_WS, 4'hF, reset wait states for region 0
R0_ADDR, 12'h000, reset base[31:20] of region 0 (boot ROM)
R0_MASK, 12'hE00, reset mask[31:20] of region 0
TOUT, 8'd255, max cycles waiting for mem_brdyn before error
BSWAP, 1, 1 = big-endian memory: byte lanes reversed on data and strobes

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
wb_adr_i  in  32  main slave address
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  WISHBONE classic controls (cti/bte not used; every beat is a classic cycle)
wb_dat_o  out  32  read data, valid while wb_ack_o=1
wb_ack_o  out  1  cycle termination, normal
wb_err_o  out  1  cycle termination, error
cfg_adr_i  in  3  config register index
cfg_dat_i  in  32  config write data
cfg_cyc_i, cfg_stb_i, cfg_we_i  in  1 each  config slave controls
cfg_dat_o  out  32  config read data
cfg_ack_o  out  1  config termination
mem_addr  out  32  memory address
mem_dout  out  32  memory write data
mem_din  in  32  memory read data
mem_drive  out  1  1 = drive mem_dout onto the pads
mem_csn  out  NREG  chip selects, active-low
mem_oen  out  1  output enable, active-low
mem_wen  out  4  per-byte write enables, active-low
mem_brdyn  in  1  external bus ready, active-low

Behaviour:
- Reset (rst_n=0 at an edge) values:
  - outputs: wb_ack_o=0, wb_err_o=0, cfg_ack_o=0, mem_csn=all 1, mem_oen=1, mem_wen=4'hF, mem_drive=0, mem_addr=0.
  - state: IDLE.
  - region 0 register = {R0_ADDR, R0_MASK, DEF_WS, wprot 0, brdy_en 0, en 1}; other regions = 0.
  - Reset mid-access aborts the access with no ack/err.
- Config register i layout: [31:20] base, [19:8] mask, [7:4] ws, [3] wprot, [2] brdy_en, [1] reserved (reads 0), [0] en.
- Config port handshake:
  - cfg_ack_o pulses for 1 cycle, one cycle after cfg_cyc_i&cfg_stb_i is sampled.
  - cfg_ack_o never asserts on two consecutive cycles; a held strobe is acked every other cycle.
  - The write takes effect at the ack edge. Reads are combinational from the indexed register.
  - Index >= NREG: write ignored, read returns 0, still acked.
- Region decode:
  - hit_i = en_i & ((wb_adr_i[31:20] & mask_i) == base_i).
  - The lowest-index hit wins.
- Main FSM, in order:
  - IDLE: on cyc&stb (with no ack/err in the previous cycle), decode the address.
    - No hit -> ERR.
    - we & wprot of the winning region -> ERR.
    - Otherwise latch region, ws, brdy_en, address, data and sel, then go SETUP.
  - SETUP (1 cycle): mem_addr valid; mem_csn[r]=0; for writes mem_drive=1 and mem_dout valid. Counter = ws. Next state ACCESS.
  - ACCESS: mem_oen=0 for reads, or mem_wen=~lanes for writes.
    - The counter decrements while nonzero.
    - Exit when counter==0 and (brdy_en==0 or mem_brdyn==0). Reads capture mem_din at this edge. Next state HOLD.
    - If brdy_en and the counter has reached 0, a second counter counts cycles with mem_brdyn=1. Reaching TOUT -> ERR, with the strobes released.
  - HOLD (1 cycle): oen/wen deasserted; csn, addr and drive held; wb_ack_o=1 with wb_dat_o valid. Next state IDLE.
  - ERR (1 cycle): wb_err_o=1, all memory strobes inactive. Next state IDLE.
- Latency: ack is high in cycle 3+ws after the strobe is sampled in IDLE, plus any brdy wait cycles.
- Byte lanes:
  - BSWAP=1: mem_dout/mem_din bytes reversed ({b0,b1,b2,b3}); lane for sel[i] is mem_wen[3-i].
  - BSWAP=0: straight mapping.
- Master abort: if wb_cyc_i drops after IDLE, the memory cycle completes through HOLD but ack/err are suppressed.
- Config writes during an access do not affect it; the latched ws/brdy_en are used. The new values apply from the next IDLE decode.
- Only one of wb_ack_o and wb_err_o is ever high; each is a 1-cycle pulse.

Test Plan:
- Reset then config reads: read idx0 -> {12'h000,12'hE00,4'hF,4'b0001}; idx1..3 -> 0; idx7 -> 0 with ack.
- Set region1 = base 12'h400, mask 12'hC00, ws=2, en. WB read 0x4000_0010 -> mem_csn=4'b1101, mem_oen low for 3 cycles, ack in cycle 5 after strobe; mem_din=0x11223344 -> wb_dat_o=0x44332211 (BSWAP=1).
- WB write to region1, sel=4'b0010, data 0x0000AB00 -> mem_wen=4'b1011 during ACCESS, mem_dout=0x00AB0000, mem_drive=1 from SETUP through HOLD.
- Access to unmapped 0xF000_0000, and a write to region1 after setting wprot -> wb_err_o 1-cycle pulse 1 cycle after strobe, no csn activity.
- Region with brdy_en=1, ws=0, mem_brdyn held high -> err after TOUT=255 busy cycles; repeat with brdyn low after 5 cycles -> ack, no err.
- Drop wb_cyc_i during ACCESS -> strobes complete normally, no ack/err, FSM back in IDLE; assert rst_n=0 mid-ACCESS -> all outputs at reset values next edge.
